// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-order pipeline stall/flush/bubble control with live-instruction tracking
module pipe_hazard_ctrl #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_halt,
    input  logic [STAGES-1:0] i_stall_req,
    input  logic [STAGES-1:0] i_flush_req,
    output logic [STAGES-1:0] o_adv,
    output logic [STAGES-1:0] o_bubble,
    output logic [STAGES-1:0] o_valid,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    logic [STAGES-1:0] flush_v;
    logic [STAGES-1:0] stall_eff;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] freeze;
    logic [STAGES-1:0] valid_nxt;
    logic              any_stall;

    // kill[j]: some valid stage older than j flushes, so the instruction in j is dead.
    // freeze[k]: an effective stall sits at k or above, so k cannot advance.
    always_comb begin
        flush_v            = i_flush_req & o_valid;
        kill               = '0;
        for (int j = STAGES - 2; j >= 0; j--) begin
            kill[j] = kill[j+1] | flush_v[j+1];
        end
        stall_eff          = i_stall_req & o_valid & ~kill;
        any_stall          = |stall_eff;
        freeze             = '0;
        freeze[STAGES-1]   = stall_eff[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            freeze[k] = freeze[k+1] | stall_eff[k];
        end
    end

    always_comb begin
        o_adv    = '0;
        o_bubble = '0;
        if (!i_halt) begin
            o_adv = ~freeze;
            for (int k = 1; k < STAGES; k++) begin
                o_bubble[k] = freeze[k-1] & ~freeze[k];
            end
        end
    end

    // Dead instructions are dropped wherever they land: in place if frozen,
    // or in the next stage if they would have moved on.
    always_comb begin
        valid_nxt = o_valid;
        if (!i_halt) begin
            valid_nxt[0] = o_adv[0] | (o_valid[0] & ~kill[0]);
            for (int k = 1; k < STAGES; k++) begin
                if (o_adv[k]) begin
                    valid_nxt[k] = ~o_bubble[k] & o_valid[k-1] & ~kill[k-1];
                end else begin
                    valid_nxt[k] = o_valid[k] & ~kill[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_valid     <= '0;
            o_stall_cnt <= '0;
        end else begin
            o_valid <= valid_nxt;
            if ((i_halt || any_stall) && (o_stall_cnt != {CNT_W{1'b1}})) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl with an instruction-tracking model
module tb_pipe_hazard_ctrl;

    localparam int STG = 5;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic           i_halt;
    logic [STG-1:0] i_stall_req;
    logic [STG-1:0] i_flush_req;
    logic [STG-1:0] o_adv;
    logic [STG-1:0] o_bubble;
    logic [STG-1:0] o_valid;
    logic [CW-1:0]  o_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.STAGES(STG), .CNT_W(CW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_halt      (i_halt),
        .i_stall_req (i_stall_req),
        .i_flush_req (i_flush_req),
        .o_adv       (o_adv),
        .o_bubble    (o_bubble),
        .o_valid     (o_valid),
        .o_stall_cnt (o_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Model: each stage holds an instruction id (0 = empty); fetch mints new ids.
    int  pipe [STG];
    int  next_id = 0;
    int  cnt_m   = 0;
    bit  live    = 0;

    function automatic int find_f();
        int f = -1;
        for (int k = 0; k < STG; k++) if (i_flush_req[k] && pipe[k] != 0) f = k;
        return f;
    endfunction

    function automatic int find_s(input int f);
        int s = -1;
        for (int k = 0; k < STG; k++) if (i_stall_req[k] && pipe[k] != 0 && k >= f) s = k;
        return s;
    endfunction

    initial for (int k = 0; k < STG; k++) pipe[k] = 0;

    always @(posedge clk) begin
        int f, s;
        if (!resetn) begin
            for (int k = 0; k < STG; k++) pipe[k] = 0;
            cnt_m = 0;
            live  = 1;
        end else if (i_halt) begin
            if (cnt_m < (1 << CW) - 1) cnt_m++;
        end else begin
            f = find_f();
            s = find_s(f);
            if (s >= 0 && cnt_m < (1 << CW) - 1) cnt_m++;
            for (int j = 0; j < f; j++) pipe[j] = 0;
            for (int k = STG - 1; k > s; k--) begin
                if (k == 0) begin
                    next_id++;
                    pipe[0] = next_id;
                end else if (s >= 0 && k == s + 1) begin
                    pipe[k] = 0;
                end else begin
                    pipe[k] = pipe[k-1];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [STG-1:0] e_adv, e_bub, e_val;
        int s;
        if (live) begin
            e_adv = '0;
            e_bub = '0;
            if (!i_halt) begin
                s = find_s(find_f());
                for (int k = 0; k < STG; k++) e_adv[k] = (k > s);
                if (s >= 0 && s + 1 < STG) e_bub[s+1] = 1'b1;
            end
            for (int k = 0; k < STG; k++) e_val[k] = (pipe[k] != 0);
            check("model_adv",    int'(o_adv),       int'(e_adv));
            check("model_bubble", int'(o_bubble),    int'(e_bub));
            check("model_valid",  int'(o_valid),     int'(e_val));
            check("model_cnt",    int'(o_stall_cnt), cnt_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_fill();
        logic [STG-1:0] exp_v;
        exp_v = '0;
        for (int i = 0; i < STG; i++) begin
            check("fill_adv", int'(o_adv), 5'b11111);
            tick();
            exp_v = {exp_v[STG-2:0], 1'b1};
            check("fill_valid", int'(o_valid), int'(exp_v));
        end
    endtask

    initial begin
        resetn = 1'b0; i_halt = 1'b0; i_stall_req = '0; i_flush_req = '0;
        idle(2);
        check("reset_valid", int'(o_valid), 0);
        check("reset_cnt",   int'(o_stall_cnt), 0);
        check("reset_adv",   int'(o_adv), 5'b11111);

        resetn = 1'b1;
        check_fill();
        check("fill_cnt", int'(o_stall_cnt), 0);

        i_stall_req = 5'b00100;
        #1;
        check("stall_adv",    int'(o_adv),    5'b11000);
        check("stall_bubble", int'(o_bubble), 5'b01000);
        tick();
        i_stall_req = '0;
        check("stall_valid", int'(o_valid),     5'b10111);
        check("stall_cnt",   int'(o_stall_cnt), 1);
        idle(3);
        check("refill1_valid", int'(o_valid), 5'b11111);

        i_flush_req = 5'b01000;
        #1;
        check("flush_adv",    int'(o_adv),    5'b11111);
        check("flush_bubble", int'(o_bubble), 5'b00000);
        tick();
        i_flush_req = '0;
        check("flush_valid", int'(o_valid),     5'b10001);
        check("flush_cnt",   int'(o_stall_cnt), 1);
        idle(5);
        check("refill2_valid", int'(o_valid), 5'b11111);

        i_stall_req = 5'b00010; i_flush_req = 5'b01000;
        #1;
        check("sf_adv",    int'(o_adv),    5'b11111);
        check("sf_bubble", int'(o_bubble), 5'b00000);
        tick();
        i_stall_req = '0; i_flush_req = '0;
        check("sf_cnt",   int'(o_stall_cnt), 1);
        check("sf_valid", int'(o_valid),     5'b10001);
        idle(5);

        i_stall_req = 5'b10000;
        #1;
        check("wb_stall_adv", int'(o_adv), 5'b00000);
        tick();
        i_stall_req = '0;
        check("wb_stall_valid", int'(o_valid), 5'b11111);
        check("wb_stall_cnt",   int'(o_stall_cnt), 2);

        i_halt = 1'b1; i_flush_req = 5'b10000;
        for (int i = 0; i < 20; i++) begin
            check("halt_adv",    int'(o_adv),    0);
            check("halt_bubble", int'(o_bubble), 0);
            tick();
            check("halt_valid",  int'(o_valid),  5'b11111);
        end
        check("halt_cnt_sat", int'(o_stall_cnt), 15);
        i_halt = 1'b0; i_flush_req = '0;

        i_stall_req = 5'b10000;
        idle(2);
        check("pre_reset_cnt", int'(o_stall_cnt), 15);
        resetn = 1'b0;
        tick();
        check("midreset_valid", int'(o_valid),     0);
        check("midreset_cnt",   int'(o_stall_cnt), 0);
        resetn = 1'b1; i_stall_req = '0;
        check_fill();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline stages; legal range 2..16; stage 0 = fetch (youngest), stage STAGES-1 = writeback (oldest).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port i_halt  input  1  global freeze (multicycle unit busy); freezes every stage.
REQ-006 SHALL have port i_stall_req  input  STAGES  bit k = stage k cannot complete this cycle (data hazard, structural hazard).
REQ-007 SHALL have port i_flush_req  input  STAGES  bit k = stage k requests that all younger stages (0..k-1) be killed (exception, redirect).
REQ-008 SHALL have port o_adv  output  STAGES  bit 0 = fetch PC enable; bit k>0 = pipeline register feeding stage k loads.
REQ-009 SHALL have port o_bubble  output  STAGES  bit k = register feeding stage k loads a bubble instead of stage k-1 contents.
REQ-010 SHALL have port o_valid  output  STAGES  registered; bit k = stage k holds a live instruction.
REQ-011 SHALL have port o_stall_cnt  output  CNT_W  saturating count of cycles with i_halt or any effective stall.

Function
REQ-012 SHALL define S = index of the highest set bit of i_stall_req (none if zero) and F = index of the highest set bit of i_flush_req (none if zero).
REQ-013 SHALL drive o_adv, o_bubble combinationally from i_halt, i_stall_req, i_flush_req and o_valid; no other combinational paths.
REQ-014 SHALL, when i_halt=1, drive o_adv=0 and o_bubble=0, hold o_valid, and ignore stall and flush requests; requesters hold them until halt drops.
REQ-015 SHALL treat a stall at stage k as effective only if o_valid[k]=1 and, when F exists, k >= F; stalls at stages below F are cancelled.
REQ-016 SHALL, with no halt and effective stall S: o_adv[k]=1 for k>S, o_adv[k]=0 for k<=S; o_bubble[S+1]=1 if S+1<STAGES.
REQ-017 SHALL, with no halt and no effective stall: o_adv = all ones, o_bubble = 0.
REQ-018 SHALL update valids (no halt): advancing stage k>0 takes o_valid[k-1] (0 if bubble); frozen stages hold; o_valid[0] becomes 1 when o_adv[0]=1.
REQ-019 SHALL, when F exists (no halt), clear o_valid[0..F-1] at the next edge, overriding REQ-018, whether those stages advance or freeze; stage F and older are unaffected by the flush.
REQ-020 SHALL let the instruction leaving stage STAGES-1 retire unconditionally; the oldest stage never holds because of younger stages.
REQ-021 SHALL increment o_stall_cnt by 1 per cycle in which i_halt=1 or an effective stall exists, saturating at 2^CNT_W-1, never wrapping.
REQ-022 SHALL ignore i_stall_req and i_flush_req bits on stages whose o_valid=0, except that flush bits are honoured only for valid stages as well.
REQ-023 SHALL treat simultaneous flush at F and stall at S>=F as: freeze per REQ-016 and clear valids per REQ-019 in the same cycle.

Reset
REQ-024 SHALL, while resetn=0 at a rising edge, set o_valid=0 and o_stall_cnt=0, regardless of i_halt, stall or flush inputs.
REQ-025 SHALL, with o_valid=0 after reset and no requests, drive o_adv all ones, so the pipeline fills one stage per cycle from stage 0.
REQ-026 SHALL apply reset mid-operation identically: all in-flight instructions discarded, counter cleared, fill restarts.

Verification (STAGES=5, CNT_W=4; vectors written [4:0])
REQ-027 SHALL verify fill: release reset, no requests -> o_valid = 00001, 00011, 00111, 01111, 11111 on successive edges; o_adv=11111 throughout.
REQ-028 SHALL verify stall: full pipe, i_stall_req=00100 one cycle -> o_adv=11000, o_bubble=01000; next o_valid=11111 with stage 3 bubble, i.e. 10111; o_stall_cnt=1.
REQ-029 SHALL verify flush: full pipe, i_flush_req=01000 -> o_adv=11111; next o_valid=10001 after stage shift plus clear (stages 0..2 zero, then fetch refills bit 0).
REQ-030 SHALL verify stall+flush: full pipe, i_stall_req=00010, i_flush_req=01000 -> stall cancelled, o_adv=11111, o_stall_cnt unchanged.
REQ-031 SHALL verify halt: full pipe, i_halt=1 for 20 cycles with i_flush_req=10000 -> o_adv=00000, o_valid held 11111, o_stall_cnt saturates at 15.
REQ-032 SHALL verify reset mid-stall: i_stall_req=10000 held, assert resetn=0 one cycle -> o_valid=00000, o_stall_cnt=0, then fill resumes per REQ-027 once stall released.
